// File: rtl/eth_rx_dispatch.sv
// Ethernet receive dispatcher: strips the MAC header, filters on destination
// and steers ARP / IPv4 frames (EtherType + payload) to their own streams.
module eth_rx_dispatch #(
  parameter logic [47:0] P_LOCAL_MAC = 48'h0000AABBCCDD,
  parameter int          P_CNT_W     = 16
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  input  logic [7:0]         S_AXIS_TDATA,
  input  logic               S_AXIS_TLAST,
  input  logic               S_AXIS_TUSER,
  output logic               M_ARP_AXIS_TVALID,
  input  logic               M_ARP_AXIS_TREADY,
  output logic [7:0]         M_ARP_AXIS_TDATA,
  output logic               M_ARP_AXIS_TLAST,
  output logic               M_ARP_AXIS_TUSER,
  output logic               M_IP_AXIS_TVALID,
  input  logic               M_IP_AXIS_TREADY,
  output logic [7:0]         M_IP_AXIS_TDATA,
  output logic               M_IP_AXIS_TLAST,
  output logic               M_IP_AXIS_TUSER,
  output logic [47:0]        O_SRC_MAC,
  output logic [P_CNT_W-1:0] O_DROP_MAC_CNT,
  output logic [P_CNT_W-1:0] O_DROP_TYPE_CNT,
  output logic [P_CNT_W-1:0] O_RUNT_CNT
);

  typedef enum logic [2:0] {
    HDR,
    EMIT_T0,
    EMIT_T1,
    PASS,
    DROP
  } state_t;

  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ET_ARP = 16'h0806;
  localparam logic [15:0] ET_IP  = 16'h0800;

  state_t      state;
  logic [3:0]  idx;
  logic [47:0] dst;
  logic [39:0] src_sr;
  logic [15:0] etype;
  logic        sel_arp;

  logic        s_rdy;
  logic        m_vld;
  logic [7:0]  m_dat;
  logic        m_lst;
  logic        m_usr;
  logic        sel_rdy;
  logic        acc;
  logic        dst_ok;
  logic [15:0] et_now;

  function automatic logic [P_CNT_W-1:0] sat_inc(
    input logic [P_CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  assign sel_rdy = sel_arp ? M_ARP_AXIS_TREADY
                           : M_IP_AXIS_TREADY;
  assign acc     = S_AXIS_TVALID & s_rdy;
  assign dst_ok  = (dst == P_LOCAL_MAC) ||
                   (dst == BCAST);
  assign et_now  = {etype[15:8], S_AXIS_TDATA};

  // Handshake and datapath muxing per state; reset blocks both sides
  always_comb begin
    s_rdy = 1'b0;
    m_vld = 1'b0;
    m_dat = 8'h00;
    m_lst = 1'b0;
    m_usr = 1'b0;
    unique case (state)
      HDR: s_rdy = 1'b1;
      EMIT_T0: begin
        m_vld = 1'b1;
        m_dat = etype[15:8];
      end
      EMIT_T1: begin
        m_vld = 1'b1;
        m_dat = etype[7:0];
      end
      PASS: begin
        m_vld = S_AXIS_TVALID;
        m_dat = S_AXIS_TDATA;
        m_lst = S_AXIS_TLAST;
        m_usr = S_AXIS_TUSER;
        s_rdy = sel_rdy;
      end
      DROP: s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
    if (I_RESET) begin
      s_rdy = 1'b0;
      m_vld = 1'b0;
    end
  end

  assign S_AXIS_TREADY     = s_rdy;
  assign M_ARP_AXIS_TVALID = m_vld & sel_arp;
  assign M_ARP_AXIS_TDATA  = m_dat;
  assign M_ARP_AXIS_TLAST  = m_lst;
  assign M_ARP_AXIS_TUSER  = m_usr;
  assign M_IP_AXIS_TVALID  = m_vld & ~sel_arp;
  assign M_IP_AXIS_TDATA   = m_dat;
  assign M_IP_AXIS_TLAST   = m_lst;
  assign M_IP_AXIS_TUSER   = m_usr;

  // Header capture, dispatch decision and frame sequencing
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state           <= HDR;
      idx             <= 4'd0;
      dst             <= 48'h0;
      src_sr          <= 40'h0;
      etype           <= 16'h0;
      sel_arp         <= 1'b0;
      O_SRC_MAC       <= 48'h0;
      O_DROP_MAC_CNT  <= '0;
      O_DROP_TYPE_CNT <= '0;
      O_RUNT_CNT      <= '0;
    end else begin
      unique case (state)
        HDR: begin
          if (acc) begin
            unique case (1'b1)
              (idx < 4'd6):
                dst <= {dst[39:0], S_AXIS_TDATA};
              (idx >= 4'd6 && idx < 4'd11):
                src_sr <= {src_sr[31:0], S_AXIS_TDATA};
              (idx == 4'd11):
                O_SRC_MAC <= {src_sr, S_AXIS_TDATA};
              (idx == 4'd12):
                etype[15:8] <= S_AXIS_TDATA;
              default:
                etype[7:0] <= S_AXIS_TDATA;
            endcase
            if (S_AXIS_TLAST) begin
              O_RUNT_CNT <= sat_inc(O_RUNT_CNT);
              idx        <= 4'd0;
            end else if (idx == 4'd13) begin
              idx <= 4'd0;
              if (!dst_ok) begin
                state          <= DROP;
                O_DROP_MAC_CNT <= sat_inc(O_DROP_MAC_CNT);
              end else if (et_now == ET_ARP) begin
                sel_arp <= 1'b1;
                state   <= EMIT_T0;
              end else if (et_now == ET_IP) begin
                sel_arp <= 1'b0;
                state   <= EMIT_T0;
              end else begin
                state           <= DROP;
                O_DROP_TYPE_CNT <= sat_inc(O_DROP_TYPE_CNT);
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        EMIT_T0: if (sel_rdy) state <= EMIT_T1;
        EMIT_T1: if (sel_rdy) state <= PASS;
        PASS:    if (acc && S_AXIS_TLAST) state <= HDR;
        DROP:    if (acc && S_AXIS_TLAST) state <= HDR;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_eth_rx_dispatch;

  localparam logic [47:0] LMAC = 48'h0000AABBCCDD;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
  localparam int          CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last, s_user;
  logic [7:0]    s_data;
  logic          arp_valid, arp_ready, arp_last, arp_user;
  logic [7:0]    arp_data;
  logic          ip_valid, ip_ready, ip_last, ip_user;
  logic [7:0]    ip_data;
  logic [47:0]   src_mac;
  logic [CW-1:0] c_mac, c_type, c_runt;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t got_arp[$], got_ip[$], exp_arp[$], exp_ip[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  bit tog = 1'b0;
  int e_mac, e_type, e_runt;
  logic [47:0] e_src;
  bit    arp_hold, ip_hold;
  beat_t arp_prev, ip_prev;

  eth_rx_dispatch #(
    .P_LOCAL_MAC(LMAC),
    .P_CNT_W    (CW)
  ) dut (
    .I_CLK            (clk),
    .I_RESET          (rst),
    .S_AXIS_TVALID    (s_valid),
    .S_AXIS_TREADY    (s_ready),
    .S_AXIS_TDATA     (s_data),
    .S_AXIS_TLAST     (s_last),
    .S_AXIS_TUSER     (s_user),
    .M_ARP_AXIS_TVALID(arp_valid),
    .M_ARP_AXIS_TREADY(arp_ready),
    .M_ARP_AXIS_TDATA (arp_data),
    .M_ARP_AXIS_TLAST (arp_last),
    .M_ARP_AXIS_TUSER (arp_user),
    .M_IP_AXIS_TVALID (ip_valid),
    .M_IP_AXIS_TREADY (ip_ready),
    .M_IP_AXIS_TDATA  (ip_data),
    .M_IP_AXIS_TLAST  (ip_last),
    .M_IP_AXIS_TUSER  (ip_user),
    .O_SRC_MAC        (src_mac),
    .O_DROP_MAC_CNT   (c_mac),
    .O_DROP_TYPE_CNT  (c_type),
    .O_RUNT_CNT       (c_runt)
  );

  always #5 clk = ~clk;

  // Downstream ready patterns: held high, alternating, or random
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (ready_mode)
      0: begin arp_ready = 1'b1; ip_ready = 1'b1; end
      1: begin arp_ready = tog;  ip_ready = tog;  end
      default: begin
        arp_ready = 1'($urandom_range(1));
        ip_ready  = 1'($urandom_range(1));
      end
    endcase
  end

  // Collect downstream beats and watch exclusivity / hold stability
  always @(negedge clk) begin
    if (arp_valid && arp_ready)
      got_arp.push_back({arp_data, arp_last, arp_user});
    if (ip_valid && ip_ready)
      got_ip.push_back({ip_data, ip_last, ip_user});
    if (arp_valid && ip_valid) begin
      errors++;
      $display("FAIL both_valid got arp=1 ip=1 exp at most one");
    end
    if (!rst && arp_hold) begin
      checks++;
      if (arp_valid !== 1'b1 ||
          {arp_data, arp_last, arp_user} !== arp_prev) begin
        errors++;
        $display("FAIL arp_hold got %h exp %h",
                 {arp_data, arp_last, arp_user}, arp_prev);
      end
    end
    if (!rst && ip_hold) begin
      checks++;
      if (ip_valid !== 1'b1 ||
          {ip_data, ip_last, ip_user} !== ip_prev) begin
        errors++;
        $display("FAIL ip_hold got %h exp %h",
                 {ip_data, ip_last, ip_user}, ip_prev);
      end
    end
    arp_hold = arp_valid && !arp_ready;
    ip_hold  = ip_valid && !ip_ready;
    arp_prev = {arp_data, arp_last, arp_user};
    ip_prev  = {ip_data, ip_last, ip_user};
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush();
    got_arp = {}; got_ip = {}; exp_arp = {}; exp_ip = {};
  endtask

  task automatic mk_frame(output logic [7:0] f[$],
                          input logic [47:0] d,
                          input logic [47:0] s,
                          input logic [15:0] et,
                          input int len);
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(s[47-8*i -: 8]);
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    while (f.size() < len) f.push_back(8'($urandom));
    while (f.size() > len) void'(f.pop_back());
  endtask

  // Frame-level reference: what each port should see, counter effects
  task automatic model(input logic [7:0] f[$], input bit u);
    int n = f.size();
    logic [47:0] d;
    logic [15:0] et;
    beat_t q[$];
    if (n >= 12)
      for (int i = 6; i < 12; i++) e_src = {e_src[39:0], f[i]};
    if (n <= 14) begin
      if (e_runt < CMAX) e_runt++;
      return;
    end
    d = '0;
    for (int i = 0; i < 6; i++) d = {d[39:0], f[i]};
    et = {f[12], f[13]};
    if (d != LMAC && d != BC) begin
      if (e_mac < CMAX) e_mac++;
      return;
    end
    if (et != 16'h0806 && et != 16'h0800) begin
      if (e_type < CMAX) e_type++;
      return;
    end
    q.push_back({f[12], 1'b0, 1'b0});
    q.push_back({f[13], 1'b0, 1'b0});
    for (int i = 14; i < n; i++)
      q.push_back({f[i], 1'(i == n-1), (i == n-1) ? u : 1'b0});
    if (et == 16'h0806) exp_arp = {exp_arp, q};
    else exp_ip = {exp_ip, q};
  endtask

  task automatic drive(input logic [7:0] f[$], input bit u,
                       input int stop, input int gap);
    int n = f.size();
    bit acc;
    int to;
    for (int i = 0; i < stop; i++) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
        idle(1);
      end
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = (i == n-1);
      s_user  = (i == n-1) ? u : 1'b0;
      acc = 1'b0;
      to  = 0;
      while (!acc && to < 2000) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        to++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_timeout byte %0d got ready=0 exp 1", i);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({s_ready, arp_valid, ip_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_hs got %b exp 000",
               {s_ready, arp_valid, ip_valid});
    end
    checks++;
    if (src_mac !== 48'h0 || {c_mac, c_type, c_runt} !== '0) begin
      errors++;
      $display("FAIL rst_regs got %h %0d %0d %0d exp 0",
               src_mac, c_mac, c_type, c_runt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b exp 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arp_bcast();
    logic [7:0] f[$];
    flush();
    ready_mode = 0;
    mk_frame(f, BC, 48'h001122334455, 16'h0806, 42);
    model(f, 1'b0);
    drive(f, 1'b0, 42, 0);
    idle(3);
    checks++;
    if (got_arp.size() != 30) begin
      errors++;
      $display("FAIL arp_len got %0d exp 30", got_arp.size());
    end
    checks++;
    if (got_arp.size() == 30 &&
        ({got_arp[0].d, got_arp[1].d} !== 16'h0806 ||
         got_arp[29].l !== 1'b1 || got_arp[28].l !== 1'b0)) begin
      errors++;
      $display("FAIL arp_ends got %h%h last=%b exp 0806 last=1",
               got_arp[0].d, got_arp[1].d, got_arp[29].l);
    end
    for (int i = 0; i < exp_arp.size(); i++) begin
      checks++;
      if (i >= got_arp.size() || got_arp[i] !== exp_arp[i]) begin
        errors++;
        $display("FAIL arp_beat[%0d] got %h exp %h",
                 i, got_arp[i], exp_arp[i]);
        break;
      end
    end
    checks++;
    if (got_ip.size() != 0 || src_mac !== 48'h001122334455) begin
      errors++;
      $display("FAIL arp_side got ip=%0d src=%h exp 0 001122334455",
               got_ip.size(), src_mac);
    end
  endtask

  task automatic test_ip_toggle();
    logic [7:0] f[$];
    flush();
    ready_mode = 1;
    mk_frame(f, LMAC, 48'h0A0B0C0D0E0F, 16'h0800, 60);
    model(f, 1'b0);
    drive(f, 1'b0, 60, 0);
    idle(3);
    checks++;
    if (got_ip.size() != 48 || got_arp.size() != 0) begin
      errors++;
      $display("FAIL ip_len got %0d/%0d exp 48/0",
               got_ip.size(), got_arp.size());
    end
    for (int i = 0; i < exp_ip.size(); i++) begin
      checks++;
      if (i >= got_ip.size() || got_ip[i] !== exp_ip[i]) begin
        errors++;
        $display("FAIL ip_beat[%0d] got %h exp %h",
                 i, got_ip[i], exp_ip[i]);
        break;
      end
    end
    checks++;
    if (src_mac !== 48'h0A0B0C0D0E0F) begin
      errors++;
      $display("FAIL ip_src got %h exp 0a0b0c0d0e0f", src_mac);
    end
    ready_mode = 0;
  endtask

  task automatic test_drops();
    logic [7:0] f[$];
    flush();
    mk_frame(f, 48'h020000000001, 48'h0, 16'h0800, 60);
    model(f, 1'b0);
    drive(f, 1'b0, 60, 10);
    idle(2);
    checks++;
    if (c_mac !== CW'(1) || c_type !== CW'(0)) begin
      errors++;
      $display("FAIL drop_mac got %0d/%0d exp 1/0", c_mac, c_type);
    end
    mk_frame(f, LMAC, 48'h0, 16'h86DD, 60);
    model(f, 1'b0);
    drive(f, 1'b0, 60, 10);
    idle(2);
    checks++;
    if (c_type !== CW'(1) || c_mac !== CW'(1)) begin
      errors++;
      $display("FAIL drop_type got %0d/%0d exp 1/1", c_type, c_mac);
    end
    checks++;
    if (got_ip.size() != 0 || got_arp.size() != 0) begin
      errors++;
      $display("FAIL drop_fwd got %0d/%0d exp 0/0",
               got_ip.size(), got_arp.size());
    end
  endtask

  task automatic test_runts();
    logic [7:0] f[$];
    flush();
    mk_frame(f, LMAC, 48'h1, 16'h0800, 10);
    model(f, 1'b0);
    drive(f, 1'b0, 10, 0);
    mk_frame(f, LMAC, 48'h2, 16'h0800, 14);
    model(f, 1'b0);
    drive(f, 1'b0, 14, 0);
    idle(2);
    checks++;
    if (c_runt !== CW'(2) || got_ip.size() != 0) begin
      errors++;
      $display("FAIL runt_cnt got %0d fwd=%0d exp 2 fwd=0",
               c_runt, got_ip.size());
    end
    mk_frame(f, BC, 48'h665544332211, 16'h0800, 20);
    model(f, 1'b0);
    drive(f, 1'b0, 20, 0);
    idle(2);
    checks++;
    if (got_ip.size() != 8) begin
      errors++;
      $display("FAIL runt_next_len got %0d exp 8", got_ip.size());
    end
    for (int i = 0; i < exp_ip.size(); i++) begin
      checks++;
      if (i >= got_ip.size() || got_ip[i] !== exp_ip[i]) begin
        errors++;
        $display("FAIL runt_next[%0d] got %h exp %h",
                 i, got_ip[i], exp_ip[i]);
        break;
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] f[$];
    int len;
    flush();
    for (int k = 0; k < 7; k++) begin
      len = $urandom_range(1, 14);
      mk_frame(f, LMAC, 48'h0, 16'h0800, len);
      model(f, 1'b0);
      drive(f, 1'b0, len, 20);
    end
    idle(2);
    checks++;
    if (c_runt !== CW'(CMAX) || c_runt !== CW'(e_runt)) begin
      errors++;
      $display("FAIL runt_sat got %0d exp %0d", c_runt, CMAX);
    end
    checks++;
    if (c_mac !== CW'(e_mac) || c_type !== CW'(e_type)) begin
      errors++;
      $display("FAIL sat_others got %0d/%0d exp %0d/%0d",
               c_mac, c_type, e_mac, e_type);
    end
  endtask

  task automatic test_tuser();
    logic [7:0] f[$];
    flush();
    ready_mode = 2;
    mk_frame(f, LMAC, 48'hDEADBEEF0001, 16'h0800, 40);
    model(f, 1'b1);
    drive(f, 1'b1, 40, 15);
    idle(3);
    checks++;
    if (got_ip.size() != 28 ||
        got_ip[got_ip.size()-1].l !== 1'b1 ||
        got_ip[got_ip.size()-1].u !== 1'b1) begin
      errors++;
      $display("FAIL tuser_last got n=%0d %h exp n=28 l=1 u=1",
               got_ip.size(), got_ip[got_ip.size()-1]);
    end
    for (int i = 0; i < exp_ip.size(); i++) begin
      checks++;
      if (i >= got_ip.size() || got_ip[i] !== exp_ip[i]) begin
        errors++;
        $display("FAIL tuser_beat[%0d] got %h exp %h",
                 i, got_ip[i], exp_ip[i]);
        break;
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[$];
    flush();
    ready_mode = 0;
    mk_frame(f, LMAC, 48'h123456789ABC, 16'h0800, 60);
    model(f, 1'b0);
    drive(f, 1'b0, 34, 0);
    s_valid = 1'b1;
    s_data  = f[34];
    rst     = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, arp_valid, ip_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_hs got %b exp 000",
               {s_ready, arp_valid, ip_valid});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    idle(1);
    rst = 1'b0;
    e_mac = 0; e_type = 0; e_runt = 0; e_src = '0;
    @(negedge clk);
    checks++;
    if (src_mac !== 48'h0 || {c_mac, c_type, c_runt} !== '0) begin
      errors++;
      $display("FAIL mid_rst_regs got %h %0d %0d %0d exp 0",
               src_mac, c_mac, c_type, c_runt);
    end
    @(posedge clk); #1;
    checks++;
    if (got_ip.size() != 22) begin
      errors++;
      $display("FAIL mid_ip_len got %0d exp 22", got_ip.size());
    end
    for (int i = 0; i < got_ip.size(); i++) begin
      checks++;
      if (got_ip[i].l !== 1'b0 || got_ip[i] !== exp_ip[i]) begin
        errors++;
        $display("FAIL mid_ip[%0d] got %h exp %h",
                 i, got_ip[i], exp_ip[i]);
        break;
      end
    end
    flush();
    ready_mode = 2;
    mk_frame(f, BC, 48'h0A1B2C3D4E5F, 16'h0806, 42);
    model(f, 1'b0);
    drive(f, 1'b0, 42, 10);
    idle(3);
    checks++;
    if (got_arp.size() != 30 || got_ip.size() != 0) begin
      errors++;
      $display("FAIL mid_arp_len got %0d/%0d exp 30/0",
               got_arp.size(), got_ip.size());
    end
    for (int i = 0; i < exp_arp.size(); i++) begin
      checks++;
      if (i >= got_arp.size() || got_arp[i] !== exp_arp[i]) begin
        errors++;
        $display("FAIL mid_arp[%0d] got %h exp %h",
                 i, got_arp[i], exp_arp[i]);
        break;
      end
    end
    checks++;
    if ({c_mac, c_type, c_runt} !== '0 ||
        src_mac !== 48'h0A1B2C3D4E5F) begin
      errors++;
      $display("FAIL mid_after got %0d %0d %0d %h exp 0 0 0 0a1b2c3d4e5f",
               c_mac, c_type, c_runt, src_mac);
    end
  endtask

  task automatic test_random();
    logic [7:0]  f[$];
    logic [47:0] d;
    logic [15:0] et;
    int len;
    bit u;
    for (int k = 0; k < 40; k++) begin
      flush();
      ready_mode = $urandom_range(2);
      case ($urandom_range(3))
        0: d = LMAC;
        1: d = BC;
        2: d = {8'h02, 40'($urandom)};
        default: d = LMAC;
      endcase
      case ($urandom_range(3))
        0: et = 16'h0806;
        1: et = 16'h0800;
        2: et = 16'h86DD;
        default: et = 16'($urandom);
      endcase
      len = $urandom_range(8, 64);
      u   = 1'($urandom_range(1));
      mk_frame(f, d, {16'($urandom), 32'($urandom)}, et, len);
      model(f, u);
      drive(f, u, len, $urandom_range(30));
      idle(3);
      checks++;
      if (got_arp.size() != exp_arp.size() ||
          got_ip.size() != exp_ip.size()) begin
        errors++;
        $display("FAIL rnd%0d_len got %0d/%0d exp %0d/%0d", k,
                 got_arp.size(), got_ip.size(),
                 exp_arp.size(), exp_ip.size());
      end
      for (int i = 0; i < exp_arp.size(); i++) begin
        checks++;
        if (i >= got_arp.size() || got_arp[i] !== exp_arp[i]) begin
          errors++;
          $display("FAIL rnd%0d_arp[%0d] got %h exp %h",
                   k, i, got_arp[i], exp_arp[i]);
          break;
        end
      end
      for (int i = 0; i < exp_ip.size(); i++) begin
        checks++;
        if (i >= got_ip.size() || got_ip[i] !== exp_ip[i]) begin
          errors++;
          $display("FAIL rnd%0d_ip[%0d] got %h exp %h",
                   k, i, got_ip[i], exp_ip[i]);
          break;
        end
      end
      checks++;
      if (c_mac !== CW'(e_mac) || c_type !== CW'(e_type) ||
          c_runt !== CW'(e_runt) || src_mac !== e_src) begin
        errors++;
        $display("FAIL rnd%0d_regs got %0d %0d %0d %h exp %0d %0d %0d %h",
                 k, c_mac, c_type, c_runt, src_mac,
                 e_mac, e_type, e_runt, e_src);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_user = 1'b0;
    arp_ready = 1'b1; ip_ready = 1'b1;
    arp_hold = 1'b0; ip_hold = 1'b0;
    arp_prev = '0; ip_prev = '0;
    e_mac = 0; e_type = 0; e_runt = 0; e_src = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_arp_bcast();
    test_ip_toggle();
    test_drops();
    test_runts();
    test_saturation();
    test_tuser();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
